// File: rtl/box_muller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : box_muller_pkg
// Description : Shared FSM state type, output width and latency defaults.
// Revision    : 1.0  initial release
// ============================================================================
package box_muller_pkg;

    localparam int DATA_W       = 32;
    localparam int ROM_LAT_DEF  = 1;
    localparam int MULT_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RNG = 3'd1,
        ST_ROM_RD   = 3'd2,
        ST_ROM_WAIT = 3'd3,
        ST_MUL_WAIT = 3'd4,
        ST_OUT      = 3'd5,
        ST_FINISH   = 3'd6
    } bm_state_e;

endpackage
`default_nettype wire

// File: rtl/box_muller_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : box_muller_ctrl_if
// Description : Valid/ready output stream carrying the Gaussian pair.
// Revision    : 1.0  initial release
// ============================================================================
interface box_muller_ctrl_if;

    logic [box_muller_pkg::DATA_W-1:0] out1;
    logic [box_muller_pkg::DATA_W-1:0] out2;
    logic                              ovr1;
    logic                              ovr2;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output out1, out2, ovr1, ovr2, out_valid,
        input  out_ready
    );

    modport slave (
        input  out1, out2, ovr1, ovr2, out_valid,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/bm_lat_timer.sv
`default_nettype none
// ============================================================================
// Module      : bm_lat_timer
// Description : Loadable 4-bit down-counter with a zero flag.
// Revision    : 1.0  initial release
// ============================================================================
module bm_lat_timer (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [3:0] i_load_val,
    output logic            o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/box_muller_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : box_muller_ctrl
// Description : Batch controller sequencing RNG, ROM reads and output pairs.
// Revision    : 1.0  initial release
// ============================================================================
module box_muller_ctrl
    import box_muller_pkg::*;
#(
    parameter int ROM_LAT  = ROM_LAT_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int CNT_W    = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    input  wire logic [CNT_W-1:0]  i_cfg_count,
    input  wire logic              i_rng_val1,
    input  wire logic              i_rng_val2,
    output logic                   o_re_sqrt,
    output logic                   o_re_csin,
    input  wire logic [DATA_W-1:0] i_res_sin,
    input  wire logic [DATA_W-1:0] i_res_cos,
    input  wire logic              i_ovr_sin,
    input  wire logic              i_ovr_cos,
    box_muller_ctrl_if.master      bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CNT_W-1:0]       o_sample_cnt,
    output logic [7:0]             o_ovr_cnt
);

    // ROM data is valid in the last ROM_WAIT cycle, the product MULT_LAT later
    localparam logic [3:0] c_ROM_LD = 4'(ROM_LAT - 1);
    localparam logic [3:0] c_MUL_LD = 4'(MULT_LAT - 1);

    bm_state_e          r_state;
    bm_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cfg_count;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   w_sample_inc;
    logic [7:0]         r_ovr_cnt;
    logic [DATA_W-1:0]  r_out1;
    logic [DATA_W-1:0]  r_out2;
    logic               r_ovr1;
    logic               r_ovr2;
    logic               w_tmr_load;
    logic [3:0]         w_tmr_val;
    logic               w_tmr_zero;
    logic               w_accept;
    logic               w_capture;
    logic               w_xfer;

    bm_lat_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    assign w_sample_inc = r_sample_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = 4'd0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (i_cfg_count != '0) ? ST_WAIT_RNG : ST_FINISH;
                end
            end
            ST_WAIT_RNG: begin
                if (i_rng_val1 && i_rng_val2) begin
                    w_state_nxt = ST_ROM_RD;
                end
            end
            ST_ROM_RD: begin
                w_tmr_load  = 1'b1;
                w_tmr_val   = c_ROM_LD;
                w_state_nxt = ST_ROM_WAIT;
            end
            ST_ROM_WAIT: begin
                if (w_tmr_zero) begin
                    if (MULT_LAT == 0) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_OUT;
                    end else begin
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = c_MUL_LD;
                        w_state_nxt = ST_MUL_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (w_tmr_zero) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = (w_sample_inc == r_cfg_count) ? ST_FINISH : ST_WAIT_RNG;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_count  <= '0;
            r_sample_cnt <= '0;
            r_ovr_cnt    <= 8'd0;
            r_out1       <= '0;
            r_out2       <= '0;
            r_ovr1       <= 1'b0;
            r_ovr2       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cfg_count  <= i_cfg_count;
                r_sample_cnt <= '0;
                r_ovr_cnt    <= 8'd0;
            end
            if (w_capture) begin
                r_out1 <= i_res_sin;
                r_out2 <= i_res_cos;
                r_ovr1 <= i_ovr_sin;
                r_ovr2 <= i_ovr_cos;
            end
            if (w_xfer) begin
                r_sample_cnt <= w_sample_inc;
                if ((r_ovr1 || r_ovr2) && (r_ovr_cnt != 8'hFF)) begin
                    r_ovr_cnt <= r_ovr_cnt + 8'd1;
                end
            end
        end
    end

    assign o_re_sqrt     = (r_state == ST_ROM_RD);
    assign o_re_csin     = (r_state == ST_ROM_RD);
    assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign o_done        = (r_state == ST_FINISH);
    assign o_sample_cnt  = r_sample_cnt;
    assign o_ovr_cnt     = r_ovr_cnt;
    assign bus.out1      = r_out1;
    assign bus.out2      = r_out2;
    assign bus.ovr1      = r_ovr1;
    assign bus.ovr2      = r_ovr2;
    assign bus.out_valid = (r_state == ST_OUT);

endmodule
`default_nettype wire
